// File: rtl/conv_control_seq.sv
// Convolution layer sequencer: FILL/RUN/DRAIN/DONE control of BRAM reads, address generators and MAC array.
// Define MUX_REG_EN to register the lane mux (+1 cycle), with accum_sload/enable_mult delayed to match.
//   state | meaning
//   IDLE  | waiting for run_req
//   FILL  | address + BRAM read latency before MAC starts
//   RUN   | pixels stepping through memory groups, MAC enabled
//   DRAIN | MAC pipeline emptying after last read
//   DONE  | one-cycle completion, sets conv_done
module conv_control_seq #(
  parameter int DATA_WIDTH        = 16,
  parameter int INPUT_NUM_MEM     = 20,
  parameter int IFMAP_PAR         = 2,
  parameter int CYCLE_INTER       = 9,
  parameter int PIXEL_CYCLE       = 96,
  parameter int OUT_FEATURE_WIDTH = 8,
  parameter int NUM_ONEMULT       = 1,
  parameter int FILL_CYCLES       = 4,
  parameter int DRAIN_CYCLES      = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                run_req,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all,
  output logic                                busy,
  output logic                                in_feature_rden,
  output logic                                weight_rden,
  output logic                                enable_addrger,
  output logic                                enable_weightaddrger,
  output logic                                enable_mult,
  output logic                                accum_sload,
  output logic [$clog2(PIXEL_CYCLE)-1:0]      count_sload,
  output logic                                start,
  output logic                                conv_done,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_a_mux_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_b_mux_all
);

`ifdef MUX_REG_EN
  localparam bit MUX_REG = 1'b1;
`else
  localparam bit MUX_REG = 1'b0;
`endif

  localparam int TOTAL      = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;
  localparam int NUM_GROUPS = INPUT_NUM_MEM / IFMAP_PAR;
  localparam int DRAIN_LEN  = DRAIN_CYCLES + (MUX_REG ? 1 : 0);
  localparam int CNT_W      = $clog2(PIXEL_CYCLE);
  localparam int PIX_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int INN_W      = (CYCLE_INTER > 1) ? $clog2(CYCLE_INTER) : 1;
  localparam int GRP_MAX    = (PIXEL_CYCLE - 1) / CYCLE_INTER;
  localparam int GRP_W      = (GRP_MAX > 0) ? $clog2(GRP_MAX + 1) : 1;
  localparam int TMR_MAX    = (FILL_CYCLES > DRAIN_LEN) ? FILL_CYCLES : DRAIN_LEN;
  localparam int TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int LW         = DATA_WIDTH * IFMAP_PAR;

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [PIX_W-1:0]  pixel_cnt;
  logic [INN_W-1:0]  inner;
  logic [GRP_W-1:0]  grp;
  logic              last_cycle, last_pixel;
  logic              sload_c, mult_c;
  logic [LW-1:0]     mux_a_c, mux_b_c;

  assign last_cycle = (count_sload == CNT_W'(PIXEL_CYCLE - 1));
  assign last_pixel = (pixel_cnt == PIX_W'(TOTAL - 1));
  assign sload_c    = (state == RUN) && (count_sload == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    busy                 = 1'b0;
    in_feature_rden      = 1'b0;
    weight_rden          = 1'b0;
    enable_addrger       = 1'b0;
    enable_weightaddrger = 1'b0;
    mult_c               = 1'b0;
    case (state)
      IDLE: if (run_req) state_nxt = FILL;
      FILL, RUN: begin
        busy                 = 1'b1;
        in_feature_rden      = 1'b1;
        weight_rden          = 1'b1;
        enable_addrger       = 1'b1;
        enable_weightaddrger = 1'b1;
        mult_c               = (state == RUN);
        if (state == FILL && timer == '0)            state_nxt = RUN;
        if (state == RUN && last_cycle && last_pixel) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // registered build: last drain cycle is covered by the delayed enable
        mult_c = !(MUX_REG && timer == '0);
        if (timer == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      if (state_nxt == FILL)       timer <= TMR_W'(FILL_CYCLES - 1);
      else if (state_nxt == DRAIN) timer <= TMR_W'(DRAIN_LEN - 1);
      else                         timer <= '0;
    end else if (timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_sload <= '0;
      pixel_cnt   <= '0;
      inner       <= '0;
      grp         <= '0;
      start       <= 1'b0;
      conv_done   <= 1'b0;
    end else begin
      start <= (state == RUN) && last_cycle && (pixel_cnt == '0);
      if (state == DONE)                conv_done <= 1'b1;
      else if (state == IDLE && run_req) conv_done <= 1'b0;
      if (state == RUN) begin
        if (last_cycle) begin
          count_sload <= '0;
          inner       <= '0;
          grp         <= '0;
          pixel_cnt   <= last_pixel ? '0 : pixel_cnt + 1'b1;
        end else begin
          count_sload <= count_sload + 1'b1;
          if (inner == INN_W'(CYCLE_INTER - 1)) begin
            inner <= '0;
            grp   <= grp + 1'b1;
          end else begin
            inner <= inner + 1'b1;
          end
        end
      end else begin
        count_sload <= '0;
        inner       <= '0;
        grp         <= '0;
        pixel_cnt   <= '0;
      end
    end
  end

  // grp values past the last memory group leave the lanes at zero
  always_comb begin
    mux_a_c = '0;
    mux_b_c = '0;
    if (state == RUN) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (grp == GRP_W'(g)) begin
          mux_a_c = in_feature_q_a_all[g*LW +: LW];
          mux_b_c = in_feature_q_b_all[g*LW +: LW];
        end
      end
    end
  end

`ifdef MUX_REG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      accum_sload            <= 1'b0;
      enable_mult            <= 1'b0;
      in_feature_q_a_mux_all <= '0;
      in_feature_q_b_mux_all <= '0;
    end else begin
      accum_sload            <= sload_c;
      enable_mult            <= mult_c;
      in_feature_q_a_mux_all <= mux_a_c;
      in_feature_q_b_mux_all <= mux_b_c;
    end
  end
`else
  assign accum_sload            = sload_c;
  assign enable_mult            = mult_c;
  assign in_feature_q_a_mux_all = mux_a_c;
  assign in_feature_q_b_mux_all = mux_b_c;
`endif

endmodule

// File: tb/tb_conv_control_seq.sv
// Randomized scoreboard bench for conv_control_seq (default build, small layer config).
module tb_conv_control_seq;
  localparam int DW    = 8;
  localparam int NM    = 4;
  localparam int PAR   = 2;
  localparam int CI    = 3;
  localparam int P     = 8;
  localparam int OFW   = 2;
  localparam int NO    = 1;
  localparam int F     = 4;
  localparam int D     = 2;
  localparam int TOTAL = OFW * OFW * NO;
  localparam int NG    = NM / PAR;
  localparam int RUN_LEN = TOTAL * P;
  localparam int END_REL = F + RUN_LEN + D + 1;

  logic              clock = 1'b0;
  logic              reset, run_req;
  logic [DW*NM-1:0]  q_a, q_b;
  logic              busy, in_feature_rden, weight_rden, enable_addrger, enable_weightaddrger;
  logic              enable_mult, accum_sload, start, conv_done;
  logic [2:0]        count_sload;
  logic [DW*PAR-1:0] mux_a, mux_b;

  conv_control_seq #(
    .DATA_WIDTH(DW), .INPUT_NUM_MEM(NM), .IFMAP_PAR(PAR), .CYCLE_INTER(CI),
    .PIXEL_CYCLE(P), .OUT_FEATURE_WIDTH(OFW), .NUM_ONEMULT(NO),
    .FILL_CYCLES(F), .DRAIN_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .run_req(run_req),
    .in_feature_q_a_all(q_a), .in_feature_q_b_all(q_b),
    .busy(busy), .in_feature_rden(in_feature_rden), .weight_rden(weight_rden),
    .enable_addrger(enable_addrger), .enable_weightaddrger(enable_weightaddrger),
    .enable_mult(enable_mult), .accum_sload(accum_sload), .count_sload(count_sload),
    .start(start), .conv_done(conv_done),
    .in_feature_q_a_mux_all(mux_a), .in_feature_q_b_mux_all(mux_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [43:0] v;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int rel        = 0;  // cycles since the accepted run_req; 0 = idle
  bit mdone      = 1'b0;

  function automatic logic [43:0] actual();
    return {busy, in_feature_rden, weight_rden, enable_addrger, enable_weightaddrger,
            enable_mult, accum_sload, count_sload, start, conv_done, mux_a, mux_b};
  endfunction

  task automatic step(input bit rq, input bit rs, input bit fixed);
    exp_t e;
    bit fill, run, drain;
    int k, c, g;
    logic [DW*PAR-1:0] ea, eb;
    @(posedge clock);
    #1;
    run_req = rq;
    reset   = rs;
    if (fixed) begin
      q_a = 32'h44332211;
      q_b = 32'hDDCCBBAA;
    end else begin
      q_a = $urandom;
      q_b = $urandom;
    end
    cyc++;
    e.cyc = cyc;
    if (rs) begin
      e.v   = '0;
      rel   = 0;
      mdone = 1'b0;
      #1;
      compared++;
      if (actual() !== 44'h0) begin
        mismatched++;
        $display("FAIL async_reset cyc %0d got %h want 0", cyc, actual());
      end
    end else begin
      fill  = (rel >= 1) && (rel <= F);
      run   = (rel > F) && (rel <= F + RUN_LEN);
      drain = (rel > F + RUN_LEN) && (rel <= F + RUN_LEN + D);
      k = rel - F - 1;
      c = run ? (k % P) : 0;
      g = c / CI;
      ea = '0;
      eb = '0;
      if (run && g < NG) begin
        for (int l = 0; l < PAR; l++) begin
          ea[l*DW +: DW] = q_a[(g*PAR + l)*DW +: DW];
          eb[l*DW +: DW] = q_b[(g*PAR + l)*DW +: DW];
        end
      end
      e.v = {fill | run | drain, fill | run, fill | run, fill | run, fill | run,
             run | drain, run && c == 0, 3'(c), run && k == P, mdone, ea, eb};
      if (rel == 0) begin
        if (rq) begin
          rel   = 1;
          mdone = 1'b0;
        end
      end else if (rel == END_REL) begin
        rel   = 0;
        mdone = 1'b1;
      end else begin
        rel++;
      end
    end
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      if (actual() !== e.v) begin
        mismatched++;
        $display("FAIL outputs cyc %0d got %h want %h", e.cyc, actual(), e.v);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    run_req = 1'b0;
    q_a     = '0;
    q_b     = '0;
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // directed run with known memory words
    step(1'b1, 1'b0, 1'b1);
    repeat (45) step(1'b0, 1'b0, 1'b1);
    // run_req held high: back-to-back runs, requests ignored while busy
    repeat (90) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    // reset mid-run, then a full normal run
    step(1'b1, 1'b0, 1'b0);
    repeat (19) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (45) step(1'b0, 1'b0, 1'b0);
    // random request pattern
    repeat (200) step($urandom_range(0, 3) == 0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
